// File: rtl/pentarv_pkg.sv
// Shared RV32 decode definitions: opcodes, control-bundle encodings and the
// Control / immGen decoders used by the decode stage.
package pentarv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_PC   = 2'd1,
    SRCA_ZERO = 2'd2
  } srca_sel_e;

  // ALUop is {funct7[5], funct3} for register ops; branches compare by subtracting.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [2:0] STR_NONE = 3'b000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_branch;
    logic       src_b_sel;
    logic [1:0] src_a_sel;
    logic [3:0] alu_op;
    logic [2:0] str_ctrl;
  } ctrl_t;

  localparam ctrl_t BUBBLE = ctrl_t'(14'd0);

  function automatic ctrl_t decode_ctrl(input logic [31:0] ins);
    ctrl_t c;
    c = BUBBLE;
    case (ins[6:0])
      OPC_OP: begin
        c.reg_write = 1'b1;
        c.alu_op    = {ins[30], ins[14:12]};
      end
      OPC_OP_IMM: begin
        c.reg_write = 1'b1;
        c.src_b_sel = 1'b1;
        c.alu_op    = {(ins[14:12] == 3'b101) & ins[30], ins[14:12]};
      end
      OPC_LOAD: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.src_b_sel  = 1'b1;
        c.str_ctrl   = ins[14:12];
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.src_b_sel = 1'b1;
        c.str_ctrl  = ins[14:12];
      end
      OPC_BRANCH: begin
        c.pc_branch = 1'b1;
        c.alu_op    = ALU_SUB;
        c.str_ctrl  = ins[14:12];
      end
      OPC_JAL: begin
        c.reg_write = 1'b1;
        c.pc_branch = 1'b1;
        c.src_a_sel = SRCA_PC;
        c.src_b_sel = 1'b1;
      end
      OPC_JALR: begin
        c.reg_write = 1'b1;
        c.pc_branch = 1'b1;
        c.src_b_sel = 1'b1;
      end
      OPC_LUI: begin
        c.reg_write = 1'b1;
        c.src_a_sel = SRCA_ZERO;
        c.src_b_sel = 1'b1;
      end
      OPC_AUIPC: begin
        c.reg_write = 1'b1;
        c.src_a_sel = SRCA_PC;
        c.src_b_sel = 1'b1;
      end
      default: c = BUBBLE;
    endcase
    if (c.src_a_sel == SRCA_RS1) c.alu_op = c.alu_op | ALU_ADD;
    else c.str_ctrl = c.str_ctrl | STR_NONE;
    return c;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OPC_STORE:          imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:         imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {ins[31:12], 12'd0};
      OPC_JAL:            imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:            imm = 32'd0;
    endcase
    return imm;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/regfile_bp.sv
// Architectural register file: NREG x XLEN, two read ports, one write port,
// synchronous clear, optional same-cycle forwarding of the WB write.
module regfile_bp #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int BYPASS_WB = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_ok_s;

  assign wr_ok_s = we && (wa != 5'd0) && ({1'b0, wa} < 6'(NREG));

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) regs_d[i] = '0;
      else if (wr_ok_s && (wa[AW-1:0] == AW'(i))) regs_d[i] = wd;
      else regs_d[i] = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Out-of-range indices (RV32E) read as zero, like x0.
  always_comb begin
    rd1 = '0;
    if ((ra1 == 5'd0) || ({1'b0, ra1} >= 6'(NREG))) rd1 = '0;
    else if ((BYPASS_WB != 0) && wr_ok_s && (wa == ra1)) rd1 = wd;
    else rd1 = regs_q[ra1[AW-1:0]];
  end

  always_comb begin
    rd2 = '0;
    if ((ra2 == 5'd0) || ({1'b0, ra2} >= 6'(NREG))) rd2 = '0;
    else if ((BYPASS_WB != 0) && wr_ok_s && (wa == ra2)) rd2 = wd;
    else rd2 = regs_q[ra2[AW-1:0]];
  end

endmodule

// File: rtl/decode_stage_hz.sv
// ID stage with ID/EX register: decode, register read with WB bypass,
// load-use stall, EX flush/hold handling.
module decode_stage_hz
  import pentarv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int BYPASS_WB = 1,
  parameter int HAZ_EN    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCplus4D,
  input  logic            validD,
  input  logic            RegWriteW,
  input  logic [4:0]      rdW,
  input  logic [XLEN-1:0] resultW,
  input  logic            flushE,
  input  logic            holdE,
  output logic            stallD,
  output logic            validE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            MemtoRegE,
  output logic            PCBranchE,
  output logic            SrcBSelE,
  output logic [1:0]      SrcASelE,
  output logic [3:0]      ALUopE,
  output logic [2:0]      strCtrlE,
  output logic [XLEN-1:0] r1E,
  output logic [XLEN-1:0] r2E,
  output logic [XLEN-1:0] immE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCplus4E,
  output logic [4:0]      rdE,
  output logic [4:0]      rs1E,
  output logic [4:0]      rs2E
);
  logic [4:0]      rs1_s, rs2_s, rd_s;
  logic [XLEN-1:0] r1_s, r2_s, imm_s;
  ctrl_t           ctrl_s;
  logic            hazard_s;

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] r1_q, r1_d, r2_q, r2_d, imm_q, imm_d, pc_q, pc_d, pc4_q, pc4_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;

  assign rs1_s = instrD[19:15];
  assign rs2_s = instrD[24:20];
  assign rd_s  = instrD[11:7];
  assign imm_s = XLEN'(signed'(imm_gen(instrD)));

  regfile_bp #(.XLEN(XLEN), .NREG(NREG), .BYPASS_WB(BYPASS_WB)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_s),
    .ra2 (rs2_s),
    .we  (RegWriteW),
    .wa  (rdW),
    .wd  (resultW),
    .rd1 (r1_s),
    .rd2 (r2_s)
  );

  // A fetch bubble must never write, store or redirect.
  always_comb begin
    ctrl_s = BUBBLE;
    if (validD) ctrl_s = decode_ctrl(instrD);
    else ctrl_s = BUBBLE;
  end

  always_comb begin
    hazard_s = 1'b0;
    if ((HAZ_EN != 0) && validD && valid_q && ctrl_q.mem_to_reg && (rd_q != 5'd0))
      hazard_s = (uses_rs1(instrD[6:0]) && (rs1_s == rd_q)) ||
                 (uses_rs2(instrD[6:0]) && (rs2_s == rd_q));
    else
      hazard_s = 1'b0;
  end

  // A flush discards the ID instruction anyway, so it never needs to stall.
  assign stallD = !flushE && (hazard_s || holdE);

  always_comb begin
    valid_d = valid_q; ctrl_d = ctrl_q;
    r1_d = r1_q; r2_d = r2_q; imm_d = imm_q; pc_d = pc_q; pc4_d = pc4_q;
    rd_d = rd_q; rs1_d = rs1_q; rs2_d = rs2_q;
    if (flushE) begin
      valid_d = 1'b0;
      ctrl_d  = BUBBLE;
    end else if (holdE) begin
      valid_d = valid_q;
    end else if (hazard_s) begin
      valid_d = 1'b0;
      ctrl_d  = BUBBLE;
    end else begin
      valid_d = validD; ctrl_d = ctrl_s;
      r1_d = r1_s; r2_d = r2_s; imm_d = imm_s; pc_d = PCD; pc4_d = PCplus4D;
      rd_d = rd_s; rs1_d = rs1_s; rs2_d = rs2_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0; ctrl_q <= BUBBLE;
      r1_q <= '0; r2_q <= '0; imm_q <= '0; pc_q <= '0; pc4_q <= '0;
      rd_q <= 5'd0; rs1_q <= 5'd0; rs2_q <= 5'd0;
    end else begin
      valid_q <= valid_d; ctrl_q <= ctrl_d;
      r1_q <= r1_d; r2_q <= r2_d; imm_q <= imm_d; pc_q <= pc_d; pc4_q <= pc4_d;
      rd_q <= rd_d; rs1_q <= rs1_d; rs2_q <= rs2_d;
    end
  end

  assign validE    = valid_q;
  assign RegWriteE = ctrl_q.reg_write;
  assign MemWriteE = ctrl_q.mem_write;
  assign MemtoRegE = ctrl_q.mem_to_reg;
  assign PCBranchE = ctrl_q.pc_branch;
  assign SrcBSelE  = ctrl_q.src_b_sel;
  assign SrcASelE  = ctrl_q.src_a_sel;
  assign ALUopE    = ctrl_q.alu_op;
  assign strCtrlE  = ctrl_q.str_ctrl;
  assign r1E       = r1_q;
  assign r2E       = r2_q;
  assign immE      = imm_q;
  assign PCE       = pc_q;
  assign PCplus4E  = pc4_q;
  assign rdE       = rd_q;
  assign rs1E      = rs1_q;
  assign rs2E      = rs2_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Randomized bench for decode_stage_hz: an RV32I/bypass instance and an
// RV32E/no-bypass instance share stimulus and are checked against a reference model.
module tb_decode_stage_hz;
  import pentarv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, validD, RegWriteW, flushE, holdE;
  logic [31:0] instrD, PCD, PCplus4D, resultW;
  logic [4:0]  rdW;

  logic        stallD_a, validE_a, RegWriteE_a, MemWriteE_a, MemtoRegE_a, PCBranchE_a, SrcBSelE_a;
  logic [1:0]  SrcASelE_a;
  logic [3:0]  ALUopE_a;
  logic [2:0]  strCtrlE_a;
  logic [31:0] r1E_a, r2E_a, immE_a, PCE_a, PCplus4E_a;
  logic [4:0]  rdE_a, rs1E_a, rs2E_a;
  logic        stallD_b, validE_b, RegWriteE_b, MemWriteE_b, MemtoRegE_b, PCBranchE_b, SrcBSelE_b;
  logic [1:0]  SrcASelE_b;
  logic [3:0]  ALUopE_b;
  logic [2:0]  strCtrlE_b;
  logic [31:0] r1E_b, r2E_b, immE_b, PCE_b, PCplus4E_b;
  logic [4:0]  rdE_b, rs1E_b, rs2E_b;

  always #5 clk = ~clk;

  decode_stage_hz u_dut (
    .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD), .PCplus4D(PCplus4D), .validD(validD),
    .RegWriteW(RegWriteW), .rdW(rdW), .resultW(resultW), .flushE(flushE), .holdE(holdE),
    .stallD(stallD_a), .validE(validE_a), .RegWriteE(RegWriteE_a), .MemWriteE(MemWriteE_a),
    .MemtoRegE(MemtoRegE_a), .PCBranchE(PCBranchE_a), .SrcBSelE(SrcBSelE_a), .SrcASelE(SrcASelE_a),
    .ALUopE(ALUopE_a), .strCtrlE(strCtrlE_a), .r1E(r1E_a), .r2E(r2E_a), .immE(immE_a),
    .PCE(PCE_a), .PCplus4E(PCplus4E_a), .rdE(rdE_a), .rs1E(rs1E_a), .rs2E(rs2E_a));

  decode_stage_hz #(.NREG(16), .BYPASS_WB(0)) u_dut_e (
    .clk(clk), .rst(rst), .instrD(instrD), .PCD(PCD), .PCplus4D(PCplus4D), .validD(validD),
    .RegWriteW(RegWriteW), .rdW(rdW), .resultW(resultW), .flushE(flushE), .holdE(holdE),
    .stallD(stallD_b), .validE(validE_b), .RegWriteE(RegWriteE_b), .MemWriteE(MemWriteE_b),
    .MemtoRegE(MemtoRegE_b), .PCBranchE(PCBranchE_b), .SrcBSelE(SrcBSelE_b), .SrcASelE(SrcASelE_b),
    .ALUopE(ALUopE_b), .strCtrlE(strCtrlE_b), .r1E(r1E_b), .r2E(r2E_b), .immE(immE_b),
    .PCE(PCE_b), .PCplus4E(PCplus4E_b), .rdE(rdE_b), .rs1E(rs1E_b), .rs2E(rs2E_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic rw, mw, m2r, pcb, srcb;
    logic [1:0] srca;
    logic [3:0] alu;
    logic [2:0] str;
  } ctl_t;

  typedef struct packed {
    logic valid, known, immk;
    ctl_t c;
    logic [31:0] r1a, r2a, r1b, r2b, imm, pc, pc4;
    logic [4:0] rd, rs1, rs2;
  } exp_t;

  exp_t        e;
  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];
  logic        stall_prev, obs_stall;

  logic [31:0] d_instr, d_imm, d_pc, d_res;
  logic        d_immk, d_valid, d_wen, d_flush, d_hold, d_rst;
  logic [4:0]  d_rdw;

  // Expected controls by instruction class.
  function automatic ctl_t ref_ctl(input logic [31:0] ins);
    ctl_t c;
    logic [6:0] op;
    logic [2:0] f3;
    c = '0; op = ins[6:0]; f3 = ins[14:12];
    c.rw   = op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
    c.mw   = (op == OPC_STORE);
    c.m2r  = (op == OPC_LOAD);
    c.pcb  = op inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
    c.srcb = op inside {OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
    c.srca = (op == OPC_JAL || op == OPC_AUIPC) ? SRCA_PC : (op == OPC_LUI) ? SRCA_ZERO : SRCA_RS1;
    c.str  = (op inside {OPC_LOAD, OPC_STORE, OPC_BRANCH}) ? f3 : 3'd0;
    if (op == OPC_OP) c.alu = {ins[30], f3};
    else if (op == OPC_OP_IMM) c.alu = {(f3 == 3'd5) && ins[30], f3};
    else if (op == OPC_BRANCH) c.alu = ALU_SUB;
    else c.alu = ALU_ADD;
    return c;
  endfunction

  function automatic logic [31:0] rd_a(input logic [4:0] i);
    if (i == 5'd0) return 32'd0;
    if (d_wen && d_rdw == i) return d_res;
    return regs_a[i];
  endfunction

  function automatic logic [31:0] rd_b(input logic [4:0] i);
    if (i == 5'd0 || i >= 5'd16) return 32'd0;
    return regs_b[i];
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  task automatic gen_instr();
    int k;
    logic [4:0] r1, r2, rd;
    logic [2:0] f3;
    logic [31:0] v;
    k = $urandom_range(0, 10); r1 = rnd_reg(); r2 = rnd_reg(); rd = rnd_reg();
    f3 = 3'($urandom_range(0, 7)); v = $urandom;
    d_immk = 1'b1;
    d_imm  = {{20{v[11]}}, v[11:0]};
    case (k)
      0: begin d_instr = {1'b0, v[0], 5'd0, r2, r1, f3, rd, OPC_OP}; d_immk = 1'b0; end
      1: d_instr = enc_i(v[11:0], r1, f3, rd, OPC_OP_IMM);
      3: d_instr = {v[11:5], r2, r1, f3, v[4:0], OPC_STORE};
      4: begin
        d_instr = {v[12], v[10:5], r2, r1, f3, v[4:1], v[11], OPC_BRANCH};
        d_imm   = {{19{v[12]}}, v[12:1], 1'b0};
      end
      5: begin
        d_instr = {v[20], v[10:1], v[11], v[19:12], rd, OPC_JAL};
        d_imm   = {{11{v[20]}}, v[20:1], 1'b0};
      end
      6: d_instr = enc_i(v[11:0], r1, 3'd0, rd, OPC_JALR);
      7: begin d_instr = {v[31:12], rd, OPC_LUI};   d_imm = {v[31:12], 12'd0}; end
      8: begin d_instr = {v[31:12], rd, OPC_AUIPC}; d_imm = {v[31:12], 12'd0}; end
      default: d_instr = enc_i(v[11:0], r1, f3, rd, OPC_LOAD);
    endcase
    d_valid = ($urandom_range(0, 7) != 0);
    d_pc    = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic set_ins(input logic [31:0] ins, input logic [31:0] imm, input logic immk);
    d_instr = ins; d_imm = imm; d_immk = immk; d_valid = 1'b1; d_pc = d_pc + 32'd4;
    d_wen = 1'b0; d_rdw = 5'd0; d_res = 32'd0; d_flush = 1'b0; d_hold = 1'b0; d_rst = 1'b0;
  endtask

  task automatic run_cycle();
    exp_t n;
    logic hz, stall, u1, u2;
    logic [6:0] op;
    @(negedge clk);
    rst = d_rst; instrD = d_instr; validD = d_valid; PCD = d_pc; PCplus4D = d_pc + 32'd4;
    RegWriteW = d_wen; rdW = d_rdw; resultW = d_res; flushE = d_flush; holdE = d_hold;
    #1;
    op = d_instr[6:0];
    u1 = !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    u2 = op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    hz = d_valid && e.valid && e.c.m2r && (e.rd != 5'd0) &&
         ((u1 && d_instr[19:15] == e.rd) || (u2 && d_instr[24:20] == e.rd));
    stall = !d_flush && (hz || d_hold);
    check_eq("stallD", {31'd0, stallD_a}, {31'd0, stall});
    check_eq("stallD_e", {31'd0, stallD_b}, {31'd0, stall});
    obs_stall = stallD_a;
    n = e;
    if (d_rst) begin
      n = '0; n.known = 1'b1; n.immk = 1'b1;
    end else if (d_flush || (!d_hold && hz)) begin
      n.valid = 1'b0; n.c = '0; n.known = 1'b0;
    end else if (!d_hold) begin
      n.valid = d_valid; n.c = d_valid ? ref_ctl(d_instr) : '0;
      n.known = 1'b1; n.immk = d_immk; n.imm = d_imm; n.pc = d_pc; n.pc4 = d_pc + 32'd4;
      n.r1a = rd_a(d_instr[19:15]); n.r2a = rd_a(d_instr[24:20]);
      n.r1b = rd_b(d_instr[19:15]); n.r2b = rd_b(d_instr[24:20]);
      n.rd = d_instr[11:7]; n.rs1 = d_instr[19:15]; n.rs2 = d_instr[24:20];
    end
    @(posedge clk); #1;
    if (d_rst) begin
      for (int i = 0; i < 32; i++) begin regs_a[i] = 32'd0; regs_b[i] = 32'd0; end
    end else if (d_wen && d_rdw != 5'd0) begin
      regs_a[d_rdw] = d_res;
      if (d_rdw < 5'd16) regs_b[d_rdw] = d_res;
    end
    e = n; stall_prev = stall;
    check_eq("validE", {31'd0, validE_a}, {31'd0, e.valid});
    check_eq("validE_e", {31'd0, validE_b}, {31'd0, e.valid});
    check_eq("ctl", {18'd0, RegWriteE_a, MemWriteE_a, MemtoRegE_a, PCBranchE_a, SrcBSelE_a,
                     SrcASelE_a, ALUopE_a, strCtrlE_a}, {18'd0, e.c});
    check_eq("ctl_e", {18'd0, RegWriteE_b, MemWriteE_b, MemtoRegE_b, PCBranchE_b, SrcBSelE_b,
                       SrcASelE_b, ALUopE_b, strCtrlE_b}, {18'd0, e.c});
    if (e.known) begin
      check_eq("r1E", r1E_a, e.r1a);
      check_eq("r2E", r2E_a, e.r2a);
      check_eq("r1E_e", r1E_b, e.r1b);
      check_eq("r2E_e", r2E_b, e.r2b);
      check_eq("PCE", PCE_a, e.pc);
      check_eq("PCplus4E", PCplus4E_a, e.pc4);
      check_eq("rd_rs", {17'd0, rdE_a, rs1E_a, rs2E_a}, {17'd0, e.rd, e.rs1, e.rs2});
      check_eq("rdE_e", {27'd0, rdE_b}, {27'd0, e.rd});
      if (e.immk) check_eq("immE", immE_a, e.imm);
    end
  endtask

  localparam logic [31:0] LW_X5  = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] ADD_X6 = 32'h0022_8333; // add x6,x5,x2

  initial begin
    e = '0; stall_prev = 1'b0; obs_stall = 1'b0; d_pc = 32'h100;
    for (int i = 0; i < 32; i++) begin regs_a[i] = 32'd0; regs_b[i] = 32'd0; end
    rst = 1'b1; instrD = 32'd0; validD = 1'b0; PCD = 32'd0; PCplus4D = 32'd0;
    RegWriteW = 1'b0; rdW = 5'd0; resultW = 32'd0; flushE = 1'b0; holdE = 1'b0;
    repeat (2) @(posedge clk);

    set_ins(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_OP_IMM), 32'd5, 1'b1);
    d_rst = 1'b1; run_cycle();
    check_eq("rst_validE", {31'd0, validE_a}, 32'd0);
    check_eq("rst_r1E", r1E_a, 32'd0);
    set_ins(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_OP_IMM), 32'd5, 1'b1); run_cycle();
    check_eq("rst_stall", {31'd0, obs_stall}, 32'd0);

    set_ins(LW_X5, 32'd0, 1'b1); run_cycle();
    set_ins(ADD_X6, 32'd0, 1'b0); run_cycle();
    check_eq("lu_stall", {31'd0, obs_stall}, 32'd1);
    check_eq("lu_bubble", {31'd0, validE_a}, 32'd0);
    run_cycle();
    check_eq("lu_release", {31'd0, obs_stall}, 32'd0);
    check_eq("lu_add_rdE", {27'd0, rdE_a}, 32'd6);

    set_ins(LW_X5, 32'd0, 1'b1); run_cycle();
    set_ins({20'h12345, 5'd5, OPC_LUI}, 32'h1234_5000, 1'b1); run_cycle();
    check_eq("nofs_lui", {31'd0, obs_stall}, 32'd0);
    set_ins(LW_X5, 32'd0, 1'b1); run_cycle();
    set_ins(enc_i(12'd1, 5'd0, 3'd0, 5'd7, OPC_OP_IMM), 32'd1, 1'b1); run_cycle();
    check_eq("nofs_addi", {31'd0, obs_stall}, 32'd0);

    set_ins(enc_i(12'd0, 5'd3, 3'd0, 5'd4, OPC_OP_IMM), 32'd0, 1'b1);
    d_wen = 1'b1; d_rdw = 5'd3; d_res = 32'hDEAD_BEEF; run_cycle();
    check_eq("byp_r1E", r1E_a, 32'hDEAD_BEEF);
    check_eq("nobyp_r1E", r1E_b, 32'd0);
    set_ins(enc_i(12'd0, 5'd3, 3'd0, 5'd4, OPC_OP_IMM), 32'd0, 1'b1); run_cycle();
    check_eq("wb_late_r1E", r1E_b, 32'hDEAD_BEEF);
    set_ins(enc_i(12'd0, 5'd0, 3'd0, 5'd4, OPC_OP_IMM), 32'd0, 1'b1);
    d_wen = 1'b1; d_rdw = 5'd0; d_res = 32'h1234_5678; run_cycle();
    check_eq("x0_r1E", r1E_a, 32'd0);

    set_ins(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_OP_IMM), 32'd5, 1'b1);
    d_flush = 1'b1; d_hold = 1'b1; run_cycle();
    check_eq("fh_validE", {31'd0, validE_a}, 32'd0);
    check_eq("fh_regwrite", {31'd0, RegWriteE_a}, 32'd0);
    check_eq("fh_stall", {31'd0, obs_stall}, 32'd0);
    set_ins(enc_i(12'd7, 5'd2, 3'd0, 5'd1, OPC_OP_IMM), 32'd7, 1'b1); run_cycle();
    for (int i = 0; i < 3; i++) begin
      set_ins({20'hABCDE, 5'd9, OPC_LUI}, 32'hABCD_E000, 1'b1); d_hold = 1'b1; run_cycle();
      check_eq("hold_immE", immE_a, 32'd7);
    end

    set_ins(enc_i(12'd0, 5'd17, 3'd0, 5'd8, OPC_OP_IMM), 32'd0, 1'b1);
    d_wen = 1'b1; d_rdw = 5'd17; d_res = 32'd5; run_cycle();
    set_ins(enc_i(12'd0, 5'd17, 3'd0, 5'd8, OPC_OP_IMM), 32'd0, 1'b1); run_cycle();
    check_eq("rv32e_x17", r1E_b, 32'd0);
    check_eq("rv32i_x17", r1E_a, 32'd5);

    for (int i = 0; i < 800; i++) begin
      if (!stall_prev) gen_instr();
      d_wen   = 1'($urandom_range(0, 1));
      d_rdw   = rnd_reg();
      d_res   = $urandom;
      d_flush = ($urandom_range(0, 9) == 0);
      d_hold  = ($urandom_range(0, 7) == 0);
      d_rst   = ($urandom_range(0, 99) == 0);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
